// File: rtl/cmp_run_monitor.sv
// Run-control monitor for an N-node Cardinal CMP: detects program completion across
// participating nodes, waits out a flush window, then reports done or a watchdog timeout.
module cmp_run_monitor #(
  parameter int                NODES        = 4,
  parameter int                INST_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                FLUSH_CYCLES = 5,
  parameter int                TIMEOUT      = 500,
  parameter logic [INST_W-1:0] HALT_INST    = {INST_W{1'b0}},
  parameter int                STICKY       = 0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NODES*INST_W-1:0]   inst_in,
  input  logic [NODES-1:0]          node_mask,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          run_cycles,
  output logic [NODES-1:0]          halted_vec,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      timeout
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int TOT_W = NODES * INST_W;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_ZERO  = {FC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // A limit beyond the counter's range can never be reached, so it must not alias a small value.
  localparam bit TO_EN     = (TIMEOUT != 0) && ((CNT_W >= 31) || ((TIMEOUT - 1) < (1 << CNT_W)));
  localparam bit STICKY_EN = (STICKY != 0);

  logic [1:0]       state_r,     state_nx_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nx_s;
  logic [CNT_W-1:0] run_r,       run_nx_s;
  logic [NODES-1:0] halted_r,    halted_nx_s;
  logic [FC_W-1:0]  flush_cnt_r, flush_cnt_nx_s;
  logic             done_r;
  logic             timeout_r;
  logic [NODES-1:0] match_s;
  logic             all_halt_s;
  logic             to_hit_s;

  // Per-node halt match (node 0 occupies the most significant word) and the completion term
  always_comb begin
    match_s    = {NODES{1'b0}};
    all_halt_s = 1'b1;
    for (int k = 0; k < NODES; k++) begin
      match_s[k] = (inst_in[TOT_W-1-k*INST_W -: INST_W] == HALT_INST);
      if (node_mask[k] && !(match_s[k] || (STICKY_EN && halted_r[k]))) begin
        all_halt_s = 1'b0;
      end else begin
        all_halt_s = all_halt_s;
      end
    end
  end

  // Watchdog compare on the pre-increment cycle count
  always_comb begin
    if (TO_EN) begin
      to_hit_s = (cnt_r == TO_LAST);
    end else begin
      to_hit_s = 1'b0;
    end
  end

  // Next-state logic: completion takes priority over the watchdog on the same edge
  always_comb begin
    state_nx_s     = state_r;
    flush_cnt_nx_s = flush_cnt_r;
    run_nx_s       = run_r;
    halted_nx_s    = halted_r;
    case (state_r)
      ST_RUN: begin
        halted_nx_s = halted_r | match_s;
        if (all_halt_s) begin
          run_nx_s       = cnt_r;
          flush_cnt_nx_s = FC_ZERO;
          state_nx_s     = (FLUSH_CYCLES == 0) ? ST_DONE : ST_FLUSH;
        end else if (to_hit_s) begin
          state_nx_s = ST_TIMEOUT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_cnt_nx_s = flush_cnt_r + FC_ONE;
        if (flush_cnt_r == FC_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      default: begin
        state_nx_s = state_r;
      end
    endcase
  end

  // Saturating cycle counter, live only while running or flushing
  always_comb begin
    if (((state_r == ST_RUN) || (state_r == ST_FLUSH)) && (cnt_r != CNT_MAX)) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_RUN;
      cnt_r       <= CNT_ZERO;
      run_r       <= CNT_ZERO;
      halted_r    <= {NODES{1'b0}};
      flush_cnt_r <= FC_ZERO;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      run_r       <= run_nx_s;
      halted_r    <= halted_nx_s;
      flush_cnt_r <= flush_cnt_nx_s;
      done_r      <= (state_nx_s == ST_DONE);
      timeout_r   <= (state_nx_s == ST_TIMEOUT);
    end
  end

  assign cycle_count = cnt_r;
  assign run_cycles  = run_r;
  assign halted_vec  = halted_r;
  assign state       = state_r;
  assign done        = done_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Randomized and directed scoreboard bench for cmp_run_monitor over three configurations
// sharing one stimulus stream, checked against an edge-index reference model.
module tb_cmp_run_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] inst_in = 32'd0;
  logic [3:0]  node_mask = 4'hF;

  logic [31:0] cc0, rc0, cc1, rc1;
  logic [3:0]  cc2, rc2;
  logic [3:0]  hv0, hv1, hv2;
  logic [1:0]  st0, st1, st2;
  logic        dn0, dn1, dn2, to0, to1, to2;

  always #5 CLK = ~CLK;

  cmp_run_monitor #(.NODES(4), .INST_W(8), .CNT_W(32), .FLUSH_CYCLES(5), .TIMEOUT(50),
                    .HALT_INST(8'h00), .STICKY(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .inst_in(inst_in), .node_mask(node_mask),
    .cycle_count(cc0), .run_cycles(rc0), .halted_vec(hv0), .state(st0),
    .done(dn0), .timeout(to0));

  cmp_run_monitor #(.NODES(4), .INST_W(8), .CNT_W(32), .FLUSH_CYCLES(5), .TIMEOUT(50),
                    .HALT_INST(8'h00), .STICKY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .inst_in(inst_in), .node_mask(node_mask),
    .cycle_count(cc1), .run_cycles(rc1), .halted_vec(hv1), .state(st1),
    .done(dn1), .timeout(to1));

  cmp_run_monitor #(.NODES(4), .INST_W(8), .CNT_W(4), .FLUSH_CYCLES(0), .TIMEOUT(0),
                    .HALT_INST(8'h00), .STICKY(1)) dut2 (
    .CLK(CLK), .RESET(RESET), .inst_in(inst_in), .node_mask(node_mask),
    .cycle_count(cc2), .run_cycles(rc2), .halted_vec(hv2), .state(st2),
    .done(dn2), .timeout(to2));

  typedef struct packed {
    logic [1:0]  st;
    logic        dn;
    logic        to;
    logic [31:0] cc;
    logic [31:0] rc;
    logic [3:0]  hv;
  } obs_t;

  // ei counts live edges since reset; detection at det_ei makes done true once ei passes det_ei+flush
  typedef struct {
    int unsigned ei;
    bit          det;
    int unsigned det_ei;
    bit          to;
    longint      run;
    logic [3:0]  hv;
  } mdl_t;

  int     st_c[3];
  int     fl_c[3];
  int     to_c[3];
  longint cmax_c[3];

  mdl_t        mdl[3];
  obs_t        exp_q[$];
  logic [7:0]  cw[4];
  obs_t        mon_e, mon_a;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic longint sat(int c, int unsigned v);
    return (longint'(v) > cmax_c[c]) ? cmax_c[c] : longint'(v);
  endfunction

  function automatic mdl_t step(mdl_t s, int c, bit rst, logic [3:0] msk);
    mdl_t       n;
    logic [3:0] m;
    bit         ah;
    n = s;
    if (rst) begin
      n.ei = 0; n.det = 1'b0; n.det_ei = 0; n.to = 1'b0; n.run = 0; n.hv = 4'b0000;
      return n;
    end
    if (s.to || (s.det && s.ei > s.det_ei + fl_c[c])) return n;
    if (!s.det) begin
      ah = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m[k] = (cw[k] == 8'h00);
        if (msk[k] && !(m[k] || (st_c[c] != 0 && s.hv[k]))) ah = 1'b0;
      end
      n.hv = s.hv | m;
      if (ah) begin
        n.det = 1'b1; n.det_ei = s.ei; n.run = sat(c, s.ei);
      end else if (to_c[c] != 0 && sat(c, s.ei) == longint'(to_c[c] - 1)) begin
        n.to = 1'b1;
      end
    end
    n.ei = s.ei + 1;
    return n;
  endfunction

  function automatic obs_t exp_of(mdl_t s, int c);
    obs_t o;
    bit   dn;
    dn   = s.det && (s.ei > s.det_ei + fl_c[c]);
    o.st = s.to ? 2'd3 : dn ? 2'd2 : s.det ? 2'd1 : 2'd0;
    o.dn = dn;
    o.to = s.to;
    o.cc = 32'(sat(c, s.ei));
    o.rc = 32'(s.run);
    o.hv = s.hv;
    return o;
  endfunction

  function automatic obs_t act_of(int c);
    case (c)
      0:       return {st0, dn0, to0, cc0, rc0, hv0};
      1:       return {st1, dn1, to1, cc1, rc1, hv1};
      default: return {st2, dn2, to2, 28'd0, cc2, 28'd0, rc2, hv2};
    endcase
  endfunction

  function automatic logic [7:0] nz();
    return 8'($urandom_range(255, 1));
  endfunction

  task automatic chk(string nm, int c, logic [31:0] a, logic [31:0] e);
    if (a !== e) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (vector %0d)", nm, c, a, e, n_vec);
    end
  endtask

  task automatic apply(bit rst, logic [7:0] w0, logic [7:0] w1, logic [7:0] w2,
                       logic [7:0] w3, logic [3:0] msk);
    cw[0] = w0; cw[1] = w1; cw[2] = w2; cw[3] = w3;
    RESET = rst;
    inst_in = {w0, w1, w2, w3};
    node_mask = msk;
    for (int c = 0; c < 3; c++) begin
      mdl[c] = step(mdl[c], c, rst, msk);
      exp_q.push_back(exp_of(mdl[c], c));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
    apply(1'b1, nz(), 8'h00, nz(), 8'h00, 4'(($urandom)));
  endtask

  task automatic scen(int kind, int len, logic [3:0] msk);
    logic [7:0] w[4];
    for (int t = 0; t < len; t++) begin
      for (int k = 0; k < 4; k++) w[k] = nz();
      case (kind)
        1: if (t == 20) for (int k = 0; k < 4; k++) w[k] = 8'h00;
        2: begin
          if (t == 10 || t == 11) w[0] = 8'h00;
          if (t >= 15) for (int k = 1; k < 4; k++) w[k] = 8'h00;
        end
        3: if (t == 30) for (int k = 0; k < 3; k++) w[k] = 8'h00;
        5: if (t == 49) for (int k = 0; k < 4; k++) w[k] = 8'h00;
        6: if (t == 3) for (int k = 0; k < 4; k++) w[k] = 8'h00;
        7: if (t == 8) for (int k = 0; k < 4; k++) w[k] = 8'h00;
        default: ;
      endcase
      apply(1'b0, w[0], w[1], w[2], w[3], msk);
    end
  endtask

  // Monitor: one expected observation per configuration per clock edge
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      for (int c = 0; c < 3; c++) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_a = act_of(c);
          n_vec++;
          chk("state",       c, 32'(mon_a.st), 32'(mon_e.st));
          chk("done",        c, 32'(mon_a.dn), 32'(mon_e.dn));
          chk("timeout",     c, 32'(mon_a.to), 32'(mon_e.to));
          chk("cycle_count", c, mon_a.cc,      mon_e.cc);
          chk("run_cycles",  c, mon_a.rc,      mon_e.rc);
          chk("halted_vec",  c, 32'(mon_a.hv), 32'(mon_e.hv));
        end
      end
    end
  end

  initial begin
    logic [7:0] rw[4];
    st_c   = '{0, 1, 1};
    fl_c   = '{5, 5, 0};
    to_c   = '{50, 50, 0};
    cmax_c = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    do_reset(); scen(1, 35, 4'hF);
    do_reset(); scen(2, 60, 4'hF);
    do_reset(); scen(3, 40, 4'h7);
    do_reset(); scen(4, 60, 4'hF);
    do_reset(); scen(5, 60, 4'hF);
    do_reset(); scen(6, 5, 4'hF);
    apply(1'b1, nz(), nz(), nz(), nz(), 4'hF);
    scen(7, 20, 4'hF);
    do_reset(); scen(4, 10, 4'h0);

    do_reset();
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++) rw[k] = ($urandom_range(3, 0) == 0) ? 8'h00 : nz();
      apply(($urandom_range(29, 0) == 0), rw[0], rw[1], rw[2], rw[3],
            ($urandom_range(3, 0) == 0) ? 4'(($urandom)) : 4'hF);
    end

    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_run_monitor.md
# cmp_run_monitor

Parametrised, synthesisable run-control monitor for an N-node Cardinal CMP. It observes each node's fetched instruction word, detects program completion (all participating nodes fetching the halt word), then counts a pipeline-flush window before asserting `done`. It also keeps a free-running cycle counter, captures the completion cycle, and raises a watchdog timeout. It sits beside the `cmp` top and drives memory-dump and end-of-simulation logic in benches, or status registers in silicon.

## Interface
- `NODES`, 4: number of monitored nodes (1–16).
- `INST_W`, 32: instruction word width.
- `CNT_W`, 32: cycle counter width.
- `FLUSH_CYCLES`, 5: cycles between completion detection and `done`; 0 means `done` follows detection directly.
- `TIMEOUT`, 500: watchdog limit in cycles; 0 disables the watchdog.
- `HALT_INST`, 0: instruction value that marks end of program (NOP).
- `STICKY`, 0: 0 means all nodes must fetch `HALT_INST` in the same cycle; 1 means each node's halt is latched.
- `CLK`, in, 1: clock. All state changes on the rising edge.
- `RESET`, in, 1: reset, synchronous, active-high.
- `inst_in`, in, `NODES*INST_W`: flattened fetched instructions. Node k occupies bits `[k*INST_W : k*INST_W+INST_W-1]`; bit 0 is the MSB.
- `node_mask`, in, `NODES`: bit k=1 means node k participates in completion.
- `cycle_count`, out, `CNT_W`: cycles since reset release.
- `run_cycles`, out, `CNT_W`: value of `cycle_count` at completion detection.
- `halted_vec`, out, `NODES`: sticky per-node flag, set once that node has fetched `HALT_INST`.
- `state`, out, 2: RUN=0, FLUSH=1, DONE=2, TIMEOUT=3.
- `done`, out, 1: high in DONE.
- `timeout`, out, 1: high in TIMEOUT.

## Operation
- Reset values: state RUN; `cycle_count`, `run_cycles`, `halted_vec`, flush counter all 0; `done` and `timeout` are 0.
- Per-node match: `m[k]` = (slice k == `HALT_INST`).
- `halted_vec[k]` is set to 1 on any RUN edge where `m[k]` is true. It is never cleared except by reset, and it updates regardless of `node_mask`.
- Completion term: `all_halt` = AND over masked k of (`m[k]` OR (`STICKY` AND `halted_vec[k]`)). Masked-off nodes are ignored. An all-zero mask makes `all_halt` true, so completion occurs on the first RUN edge.
- With `STICKY`=0, a node that halts and then fetches a non-halt word blocks completion until all masked nodes match in the same cycle.
- `cycle_count` increments on every non-reset edge while in RUN or FLUSH. It holds in DONE and TIMEOUT and saturates at all-ones.
- RUN transitions:
  - If `all_halt` is true: `run_cycles` <= `cycle_count` (the pre-increment value), flush counter <= 0, next state FLUSH (or DONE if `FLUSH_CYCLES`=0).
  - Else if `TIMEOUT`≠0 and `cycle_count`==`TIMEOUT`-1: next state TIMEOUT.
  - If completion and timeout occur on the same edge, completion wins.
- FLUSH: the flush counter increments each edge. The edge on which it equals `FLUSH_CYCLES`-1 moves the block to DONE. There is no watchdog in FLUSH, and `inst_in` is ignored.
- DONE and TIMEOUT are terminal until reset. `inst_in` and `node_mask` are ignored in both.
- `node_mask` is sampled every RUN edge, and changing it mid-run takes effect immediately.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Detection is evaluated at the rising edge using the current `inst_in`. `state` and `run_cycles` update at that same edge.
- Latency from the detection edge to `done`=1 is `FLUSH_CYCLES` edges, or the same edge if `FLUSH_CYCLES`=0.
- `cycle_count` equals the number of non-reset edges taken in RUN/FLUSH. It reads 0 until the first edge with `RESET` low.
- `RESET` asserted in any state, including mid-FLUSH, DONE or TIMEOUT, restores the reset values on that edge. Counting restarts on the first edge with `RESET` low.
- While `RESET` is high, `inst_in` is ignored and `halted_vec` does not update.

## Test plan
- Parameters NODES=4, STICKY=0, FLUSH=5: all four nodes fetch 0 on the edge where `cycle_count`=20 -> `run_cycles`=20, FLUSH on that edge, `done`=1 five edges later, `cycle_count` frozen at 26, `halted_vec`=4'b1111.
- STICKY=0 staggered halts: node 0 matches at count 10, returns non-zero at count 12, and nodes 1–3 match from count 15 -> no completion, `halted_vec`=4'b1111, RUN continues. The same stimulus with STICKY=1 -> `run_cycles`=15 and `done` five edges later.
- `node_mask`=4'b0111 with node 3 never halting and nodes 0–2 halting at count 30 -> `run_cycles`=30, `done`=1, `halted_vec[3]`=0.
- TIMEOUT=50 with no halts -> the edge at count 49 enters TIMEOUT, `timeout`=1, `state`=3, `cycle_count` frozen at 50, `done` stays 0. TIMEOUT=0 runs indefinitely, and the counter saturates with CNT_W=4 at 15.
- All nodes halt exactly at count 49 with TIMEOUT=50 -> FLUSH, not TIMEOUT. FLUSH_CYCLES=0 gives `done`=1 on the detection edge.
- `RESET` pulsed for one cycle during FLUSH -> all outputs are 0 and state is RUN. A rerun with halts at count 8 gives `run_cycles`=8.
